// File: rtl/switch_reader.sv
// Front-panel switch reader: two-flop synchroniser, shared sample prescaler,
// per-bit debounce with press/release strobes and an acknowledge-cleared pending flag.
module switch_reader #(
    parameter int WIDTH          = 8,
    parameter int SAMPLE_DIVIDER = 10_000,
    parameter int STABLE_SAMPLES = 10,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    input  logic [WIDTH-1:0] ack,
    output logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] released,
    output logic [WIDTH-1:0] pending,
    output logic             sample_tick
);

    localparam int               CW        = $clog2(SAMPLE_DIVIDER) + 1;
    localparam logic [CW-1:0]    DIV_LAST  = CW'(SAMPLE_DIVIDER - 1);
    localparam logic             POL       = (ACTIVE_LOW != 0);
    localparam logic [WIDTH-1:0] IDLE_PINS = {WIDTH{POL}};
    localparam logic [7:0]       STABLE_N  = 8'(STABLE_SAMPLES);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_level;
    logic [CW-1:0]    r_presc;
    logic [CW-1:0]    w_presc_next;
    logic             r_tick;

    assign w_level      = r_sync2 ^ IDLE_PINS;
    assign w_presc_next = (r_presc == DIV_LAST) ? '0 : r_presc + CW'(1);

    // Tick is registered so it is high exactly while the prescaler sits at its last value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= IDLE_PINS;
            r_sync2 <= IDLE_PINS;
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= pins;
            r_sync2 <= r_sync1;
            r_presc <= w_presc_next;
            r_tick  <= (w_presc_next == DIV_LAST);
        end
    end

    assign sample_tick = r_tick;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [7:0] r_cnt;
            logic       r_stable;
            logic       r_press;
            logic       r_rel;
            logic       r_pend;
            logic [7:0] w_cnt_inc;
            logic       w_differs;
            logic       w_qualify;

            assign w_cnt_inc = r_cnt + 8'd1;
            assign w_differs = w_level[gi] ^ r_stable;
            assign w_qualify = r_tick & w_differs & (w_cnt_inc == STABLE_N);

            // Strobes register together with the stable bit so they align with switches.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_cnt    <= 8'd0;
                    r_stable <= 1'b0;
                    r_press  <= 1'b0;
                    r_rel    <= 1'b0;
                    r_pend   <= 1'b0;
                end else begin
                    r_press <= w_qualify & w_level[gi];
                    r_rel   <= w_qualify & ~w_level[gi];
                    r_pend  <= (r_pend & ~ack[gi]) | r_press;
                    if (r_tick) begin
                        if (!w_differs) begin
                            r_cnt <= 8'd0;
                        end else if (w_qualify) begin
                            r_stable <= w_level[gi];
                            r_cnt    <= 8'd0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
            end

            assign switches[gi] = r_stable;
            assign pressed[gi]  = r_press;
            assign released[gi] = r_rel;
            assign pending[gi]  = r_pend;
        end
    endgenerate

endmodule

// File: tb/tb_switch_reader.sv
// Directed bench for switch_reader with a 4-cycle sample period and 3-sample qualification.
module tb_switch_reader;

    logic       clock;
    logic       reset;
    logic [7:0] pins;
    logic [7:0] ack;
    logic [7:0] switches;
    logic [7:0] pressed;
    logic [7:0] released;
    logic [7:0] pending;
    logic       sample_tick;

    int checks   = 0;
    int failures = 0;
    logic bounce_seen;

    switch_reader #(
        .WIDTH(8),
        .SAMPLE_DIVIDER(4),
        .STABLE_SAMPLES(3),
        .ACTIVE_LOW(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pins(pins),
        .ack(ack),
        .switches(switches),
        .pressed(pressed),
        .released(released),
        .pending(pending),
        .sample_tick(sample_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Leaves the bench on the falling edge inside a sample_tick cycle.
    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clock);
            if (sample_tick) found = 1'b1;
        end
        check("tick_found", 32'(found), 32'd1);
    endtask

    task automatic mon(input int n);
        repeat (n) begin
            @(negedge clock);
            if (switches[3] || pressed[3] || pending[3]) bounce_seen = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1;
        pins  = 8'hFF;
        ack   = 8'h00;

        $display("phase reset");
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_sw",   32'(switches), 32'h00);
        check("rst_pend", 32'(pending),  32'h00);
        check("rst_tick", 32'(sample_tick), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            check("tick_pattern", 32'(sample_tick), 32'((k % 4) == 3));
        end
        check("idle_sw",    32'(switches), 32'h00);
        check("idle_press", 32'(pressed),  32'h00);

        $display("phase clean press bit0");
        wait_tick();
        pins = 8'hFE;
        step(12);
        check("press_early_sw", 32'(switches), 32'h00);
        step(1);
        check("press_sw",    32'(switches), 32'h01);
        check("press_strb",  32'(pressed),  32'h01);
        check("press_pend0", 32'(pending),  32'h00);
        step(1);
        check("press_strb_end", 32'(pressed), 32'h00);
        check("press_pend",     32'(pending), 32'h01);
        step(8);
        check("press_pend_hold", 32'(pending),  32'h01);
        check("press_sw_hold",   32'(switches), 32'h01);

        $display("phase bounce bit3");
        bounce_seen = 1'b0;
        wait_tick();
        for (int r = 0; r < 5; r++) begin
            pins = 8'hF6;
            mon(8);
            pins = 8'hFE;
            mon(4);
        end
        mon(16);
        check("bounce_bit3", 32'(bounce_seen), 32'd0);
        check("bounce_sw",   32'(switches),    32'h01);

        $display("phase release bit0");
        wait_tick();
        pins = 8'hFF;
        step(12);
        check("rel_early_sw", 32'(switches), 32'h01);
        step(1);
        check("rel_strb",    32'(released), 32'h01);
        check("rel_sw",      32'(switches), 32'h00);
        check("rel_no_press", 32'(pressed), 32'h00);
        step(1);
        check("rel_strb_end", 32'(released), 32'h00);
        check("rel_pend_kept", 32'(pending), 32'h01);

        $display("phase press+ack collision bit0");
        wait_tick();
        pins = 8'hFE;
        step(13);
        check("coll_strb", 32'(pressed), 32'h01);
        ack = 8'h01;
        step(1);
        check("coll_pend_set_wins", 32'(pending), 32'h01);
        step(1);
        check("coll_pend_acked", 32'(pending), 32'h00);
        ack = 8'h00;

        $display("phase release bit0 again");
        wait_tick();
        pins = 8'hFF;
        step(13);
        check("rel2_strb", 32'(released), 32'h01);
        check("rel2_sw",   32'(switches), 32'h00);
        step(1);
        check("rel2_strb_end", 32'(released), 32'h00);

        $display("phase ack on idle bits");
        ack = 8'hFF;
        step(1);
        check("ack_idle_pend", 32'(pending), 32'h00);
        ack = 8'h00;

        $display("phase multi-bit press with ack[7] held");
        ack = 8'h80;
        wait_tick();
        pins = 8'h5A;
        step(12);
        check("multi_early_sw", 32'(switches), 32'h00);
        step(1);
        check("multi_strb",  32'(pressed),  32'hA5);
        check("multi_sw",    32'(switches), 32'hA5);
        check("multi_pend0", 32'(pending),  32'h00);
        step(1);
        check("multi_strb_end", 32'(pressed), 32'h00);
        check("multi_pend",     32'(pending), 32'hA5);
        step(1);
        check("multi_pend_ack7", 32'(pending), 32'h25);
        ack = 8'h00;
        step(1);
        check("multi_pend_hold", 32'(pending), 32'h25);

        $display("phase reset mid-qualification bit1");
        wait_tick();
        pins = 8'hFD;
        step(10);
        check("mid_sw_before", 32'(switches), 32'hA5);
        reset = 1'b1;
        #1;
        check("mid_rst_sw",   32'(switches), 32'h00);
        check("mid_rst_pend", 32'(pending),  32'h00);
        check("mid_rst_rel",  32'(released), 32'h00);
        check("mid_rst_tick", 32'(sample_tick), 32'd0);
        step(3);
        check("mid_rst_hold_sw", 32'(switches), 32'h00);
        reset = 1'b0;
        step(3);
        check("mid_first_tick", 32'(sample_tick), 32'd1);
        step(8);
        check("mid_early_strb", 32'(pressed),  32'h00);
        check("mid_early_sw",   32'(switches), 32'h00);
        step(1);
        check("mid_strb", 32'(pressed),  32'h02);
        check("mid_sw",   32'(switches), 32'h02);
        step(1);
        check("mid_pend",     32'(pending), 32'h02);
        check("mid_strb_end", 32'(pressed), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_reader.md
Name: switch_reader

Overview:
- Input-side counterpart to the LED driver: reads 8 front-panel push-buttons/switches into the design.
- Synchronises raw pins to `clock`, debounces each bit independently, presents stable levels, one-cycle press/release strobes, and a sticky per-bit "pressed" flag that software/logic clears by acknowledge.
- Sits between board pins and CPU-visible glue/test logic.

Parameters:
- WIDTH, 8, number of switch inputs.
- SAMPLE_DIVIDER, 10_000, clock cycles between debounce samples (1 ms at 10 MHz).
- STABLE_SAMPLES, 10, consecutive differing samples required to accept a new level (range 1..255).
- ACTIVE_LOW, 1, 1 = pin low means pressed; 0 = pin high means pressed.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- pins  input  WIDTH  raw, asynchronous switch pins.
- ack  input  WIDTH  per-bit clear of `pending`, sampled each clock.
- switches  output  WIDTH  debounced level, 1 = pressed.
- pressed  output  WIDTH  one-cycle strobe on accepted 0->1 of `switches`.
- released  output  WIDTH  one-cycle strobe on accepted 1->0 of `switches`.
- pending  output  WIDTH  sticky: set by press, cleared by `ack`.
- sample_tick  output  1  one-cycle strobe when the debounce sample occurs (debug/test visibility).

Behaviour:
- Reset (async assert, sync-safe release): `switches`, `pressed`, `released`, `pending`, `sample_tick` = 0. Sync flops load the not-pressed pin level (all 1s if ACTIVE_LOW, else 0s). Prescaler and all per-bit counters = 0.
- Polarity: pin value XORed with ACTIVE_LOW after synchronisation, so internal `level` is 1 = pressed.
- Synchroniser: 2 flops per bit; `level` reflects a pin change 2 clocks later.
- Prescaler: counts 0..SAMPLE_DIVIDER-1 and wraps. `sample_tick` is registered high for exactly the one cycle in which the count equals SAMPLE_DIVIDER-1.
  - SAMPLE_DIVIDER=1 means a tick every cycle.
  - Counter width is $clog2(SAMPLE_DIVIDER)+1.
- Per-bit debounce (state = stable bit plus an 8-bit count), evaluated only on tick cycles:
  - If `level` != stable: count+1. If count+1 == STABLE_SAMPLES, then stable <= level and count <= 0.
  - If `level` == stable: count <= 0. A glitch shorter than STABLE_SAMPLES ticks therefore restarts qualification.
  - Non-tick cycles: count holds.
  - The count never exceeds STABLE_SAMPLES-1.
- Strobes:
  - `pressed[i]` / `released[i]` are high in the same cycle `switches[i]` first shows its new value, for exactly one cycle.
  - They are never both high for the same bit.
  - Multiple bits may strobe in the same cycle.
- Pending:
  - `pending[i]` <= (`pending[i]` & ~`ack[i]`) | `pressed[i]`.
  - Simultaneous press and ack on the same bit: set wins, so `pending` stays 1.
  - Ack on a bit that is not pending has no effect.
  - Ack held high does not block a later press from setting the bit.
- Latency from pin edge to `switches` update: 2 sync cycles + wait to next tick + (STABLE_SAMPLES-1)×SAMPLE_DIVIDER cycles, with registered output on the qualifying tick edge.
- Reset mid-qualification discards partial counts. After release, qualification restarts from zero against stable=0; a switch held pressed through reset is re-reported as a press.

Test Plan (bench parameters: SAMPLE_DIVIDER=4, STABLE_SAMPLES=3, ACTIVE_LOW=1):
- Reset behaviour: with pins=8'hFF, assert reset for 3 cycles, then release. Required: all outputs 0; `sample_tick` pulses every 4th cycle thereafter.
- Clean press: drive pins[0]=0 and hold. Required: `switches`=8'h01 after the 3rd tick following sync. `pressed`=8'h01 for exactly 1 cycle in that same cycle. `pending`=8'h01 and stays set.
- Bounce rejection: toggle pins[3] low for 2 ticks, high for 1 tick, repeated 5 times, then hold high. Required: `switches[3]`, `pressed[3]` and `pending[3]` never assert.
- Release and ack collision: with bit 0 pending, assert ack=8'h01 in the same cycle a new press strobe fires on bit 0. Required: `pending[0]`=1. Ack alone one cycle later: `pending[0]`=0. Releasing pin 0 gives `released`=8'h01 for 1 cycle and `switches`=0.
- Multi-bit: drive pins=8'h5A (bits 0, 2, 5, 7 pressed) simultaneously. Required: `pressed`=8'hA5 in a single cycle; `switches`=8'hA5.
- Reset mid-operation: hold pins[1]=0, assert reset after 2 qualifying ticks, release. Required: outputs 0 during reset; `pressed[1]` asserts only after 3 full ticks counted after release.
